// File: rtl/axi4lite_data_mem_slave_pkg.sv
// Shared types and constants for the AXI4-Lite data-memory responder.
// Holds the response codes and the write/read FSM state encodings.
package axi4lite_data_mem_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_e;

endpackage

// File: rtl/axi4lite_data_mem_slave_byte_en_ram.sv
// Word-wide RAM with per-byte write enables and a registered, read-first read port.
module axi4lite_data_mem_slave_byte_en_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane writes; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Registered read; same-edge writes are seen only by the next read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= 32'h0000_0000;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4lite_data_mem_slave.sv
// AXI4-Lite responder for the CPU data RAM: independent write (AW+W->B) and read (AR->R)
// channels, byte-strobed writes, SLVERR for addresses outside the RAM window.
module axi4lite_data_mem_slave
    import axi4lite_data_mem_slave_pkg::*;
#(
    parameter int             AW          = 32,
    parameter logic [AW-1:0]  BASE_ADDR   = {AW{1'b0}},
    parameter int             DEPTH_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] s_awaddr,
    input  logic          s_awvalid,
    output logic          s_awready,
    input  logic [31:0]   s_wdata,
    input  logic [3:0]    s_wstrb,
    input  logic          s_wvalid,
    output logic          s_wready,
    output logic [1:0]    s_bresp,
    output logic          s_bvalid,
    input  logic          s_bready,
    input  logic [AW-1:0] s_araddr,
    input  logic          s_arvalid,
    output logic          s_arready,
    output logic [31:0]   s_rdata,
    output logic [1:0]    s_rresp,
    output logic          s_rvalid,
    input  logic          s_rready
);

    localparam int            IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] SPAN  = AW'(1) << (IDX_W + 2);

    wstate_e       r_wstate, w_wnext;
    rstate_e       r_rstate, w_rnext;
    logic [AW-1:0] r_awaddr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_awready, r_wready, r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_arready, r_rvalid, r_rd_ok;
    logic [1:0]    r_rresp;

    logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [AW-1:0] w_wr_addr, w_wr_off, w_rd_off;
    logic [31:0]   w_wr_data, w_ram_rdata;
    logic [3:0]    w_wr_strb, w_ram_we;
    logic          w_wr_in_range, w_rd_in_range;

    assign w_aw_hs = s_awvalid & r_awready;
    assign w_w_hs  = s_wvalid & r_wready;
    assign w_ar_hs = s_arvalid & r_arready;

    // The half that arrives on the committing edge comes straight from the bus.
    assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : s_awaddr;
    assign w_wr_data = (r_wstate == W_HAVE_W)  ? r_wdata  : s_wdata;
    assign w_wr_strb = (r_wstate == W_HAVE_W)  ? r_wstrb  : s_wstrb;

    // Modular offset: addresses below BASE_ADDR wrap high and fall outside the window.
    assign w_wr_off      = w_wr_addr - BASE_ADDR;
    assign w_rd_off      = s_araddr - BASE_ADDR;
    assign w_wr_in_range = (w_wr_off < SPAN);
    assign w_rd_in_range = (w_rd_off < SPAN);

    assign w_commit = (w_wnext == W_RESP) && (r_wstate != W_RESP);
    assign w_ram_we = (w_commit && w_wr_in_range) ? w_wr_strb : 4'b0000;

    axi4lite_data_mem_slave_byte_en_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_ram_we),
        .i_waddr (w_wr_off[IDX_W+1:2]),
        .i_wdata (w_wr_data),
        .i_re    (w_ar_hs),
        .i_raddr (w_rd_off[IDX_W+1:2]),
        .o_rdata (w_ram_rdata)
    );

    // Write FSM next state.
    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wnext = W_RESP;
                end else if (w_aw_hs) begin
                    w_wnext = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wnext = W_HAVE_W;
                end else begin
                    w_wnext = W_IDLE;
                end
            end
            W_HAVE_AW: w_wnext = w_w_hs  ? W_RESP : W_HAVE_AW;
            W_HAVE_W:  w_wnext = w_aw_hs ? W_RESP : W_HAVE_W;
            W_RESP:    w_wnext = s_bready ? W_IDLE : W_RESP;
            default:   w_wnext = W_IDLE;
        endcase
    end

    // Write state, captured halves and registered AW/W/B handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= {AW{1'b0}};
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'b0000;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_RESP_OKAY;
        end else begin
            r_wstate  <= w_wnext;
            r_awready <= (w_wnext == W_IDLE) || (w_wnext == W_HAVE_W);
            r_wready  <= (w_wnext == W_IDLE) || (w_wnext == W_HAVE_AW);
            r_bvalid  <= (w_wnext == W_RESP);
            if (w_aw_hs) begin
                r_awaddr <= s_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (w_commit) begin
                r_bresp <= w_wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  w_rnext = w_ar_hs  ? R_RESP : R_IDLE;
            R_RESP:  w_rnext = s_rready ? R_IDLE : R_RESP;
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read state and registered AR/R handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= AXI_RESP_OKAY;
            r_rd_ok   <= 1'b0;
        end else begin
            r_rstate  <= w_rnext;
            r_arready <= (w_rnext == R_IDLE);
            r_rvalid  <= (w_rnext == R_RESP);
            if (w_ar_hs) begin
                r_rresp <= w_rd_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                r_rd_ok <= w_rd_in_range;
            end
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rd_ok ? w_ram_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_axi4lite_data_mem_slave.sv
// Directed self-checking bench for axi4lite_data_mem_slave (default parameters).
module tb_axi4lite_data_mem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_awaddr = 32'h0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = 32'h0;
    logic [3:0]  s_wstrb = 4'h0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = 32'h0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    axi4lite_data_mem_slave dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            output logic [1:0] resp);
        logic aw_done, w_done, a_hs, w_hs;
        int cnt;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; cnt = 0;
        while (!(aw_done && w_done) && cnt < 20) begin
            a_hs = s_awvalid && s_awready;
            w_hs = s_wvalid && s_wready;
            tick();
            cnt++;
            if (a_hs) begin aw_done = 1'b1; s_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1'b1; s_wvalid = 1'b0; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        cnt = 0;
        while (!s_bvalid && cnt < 20) begin tick(); cnt++; end
        chk("wr_bvalid", 32'(s_bvalid), 32'd1);
        resp = s_bresp;
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic done, hs;
        int cnt;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
        done = 1'b0; cnt = 0;
        while (!done && cnt < 20) begin
            hs = s_arvalid && s_arready;
            tick();
            cnt++;
            if (hs) begin done = 1'b1; s_arvalid = 1'b0; end
        end
        s_arvalid = 1'b0;
        cnt = 0;
        while (!s_rvalid && cnt < 20) begin tick(); cnt++; end
        chk("rd_rvalid", 32'(s_rvalid), 32'd1);
        d = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [1:0]  bs;

        // Reset
        tick(); tick();
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready",  32'(s_wready),  32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_bresp",   32'(s_bresp),   32'd0);
        chk("rst_rresp",   32'(s_rresp),   32'd0);
        chk("rst_rdata",   s_rdata,        32'h0);
        rst = 1'b1;
        chk("rel_awready_low", 32'(s_awready), 32'd0);
        tick();
        chk("rel_awready", 32'(s_awready), 32'd1);
        chk("rel_wready",  32'(s_wready),  32'd1);
        chk("rel_arready", 32'(s_arready), 32'd1);

        // 1: combined AW+W, minimum-latency B, then 1-cycle read
        s_awaddr = 32'h10; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t1_bvalid",  32'(s_bvalid),  32'd1);
        chk("t1_bresp",   32'(s_bresp),   32'd0);
        chk("t1_awready", 32'(s_awready), 32'd0);
        tick();
        s_bready = 1'b0;
        chk("t1_bvalid_done", 32'(s_bvalid),  32'd0);
        chk("t1_awready_back", 32'(s_awready), 32'd1);
        s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b0;
        tick();
        s_arvalid = 1'b0;
        chk("t1_rvalid",  32'(s_rvalid),  32'd1);
        chk("t1_rdata",   s_rdata,        32'hDEADBEEF);
        chk("t1_rresp",   32'(s_rresp),   32'd0);
        chk("t1_arready", 32'(s_arready), 32'd0);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("t1_rvalid_done", 32'(s_rvalid), 32'd0);

        // 2: single-byte strobe at unaligned address
        do_write(32'h12, 32'h00AA0000, 4'b0100, bs);
        chk("t2_bresp", 32'(bs), 32'd0);
        do_read(32'h10, rd, rs);
        chk("t2_rdata", rd, 32'hDEAABEEF);

        // 3: W before AW, B backpressure
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        tick();
        s_wvalid = 1'b0;
        chk("t3_wready_held",  32'(s_wready),  32'd0);
        chk("t3_awready_held", 32'(s_awready), 32'd1);
        chk("t3_bvalid_early", 32'(s_bvalid),  32'd0);
        tick(); tick();
        s_awaddr = 32'h30; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("t3_bvalid", 32'(s_bvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_bvalid_hold",  32'(s_bvalid),  32'd1);
            chk("t3_bresp_hold",   32'(s_bresp),   32'd0);
            chk("t3_awready_hold", 32'(s_awready), 32'd0);
            chk("t3_wready_hold",  32'(s_wready),  32'd0);
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("t3_bvalid_done", 32'(s_bvalid),  32'd0);
        chk("t3_wready_back", 32'(s_wready),  32'd1);
        do_read(32'h30, rd, rs);
        chk("t3_rdata", rd, 32'h12345678);

        // 4: out-of-range write/read leave word 0 alone
        do_write(32'h0, 32'hCAFEF00D, 4'hF, bs);
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, bs);
        chk("t4_bresp", 32'(bs), 32'd2);
        do_read(32'h1000, rd, rs);
        chk("t4_rdata", rd, 32'h0);
        chk("t4_rresp", 32'(rs), 32'd2);
        do_read(32'h0, rd, rs);
        chk("t4_word0", rd, 32'hCAFEF00D);
        chk("t4_word0_resp", 32'(rs), 32'd0);

        // 5: same-edge write and read of one word is read-first
        do_write(32'h20, 32'h22222222, 4'hF, bs);
        s_awaddr = 32'h20; s_wdata = 32'h11111111; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 32'h20; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("t5_rvalid", 32'(s_rvalid), 32'd1);
        chk("t5_rdata_old", s_rdata, 32'h22222222);
        chk("t5_bvalid", 32'(s_bvalid), 32'd1);
        s_rready = 1'b1; s_bready = 1'b1;
        tick();
        s_rready = 1'b0; s_bready = 1'b0;
        do_read(32'h20, rd, rs);
        chk("t5_rdata_new", rd, 32'h11111111);

        // 6: reset with both responses pending
        s_awaddr = 32'h40; s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        s_araddr = 32'h10; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("t6_bvalid_pre", 32'(s_bvalid), 32'd1);
        chk("t6_rvalid_pre", 32'(s_rvalid), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6_bvalid",  32'(s_bvalid),  32'd0);
        chk("t6_rvalid",  32'(s_rvalid),  32'd0);
        chk("t6_awready", 32'(s_awready), 32'd0);
        chk("t6_wready",  32'(s_wready),  32'd0);
        chk("t6_arready", 32'(s_arready), 32'd0);
        chk("t6_rdata",   s_rdata,        32'h0);
        rst = 1'b1;
        chk("t6_arready_rel", 32'(s_arready), 32'd0);
        tick();
        chk("t6_awready_up", 32'(s_awready), 32'd1);
        chk("t6_arready_up", 32'(s_arready), 32'd1);
        do_read(32'h40, rd, rs);
        chk("t6_persist_40", rd, 32'h5A5A5A5A);
        do_read(32'h10, rd, rs);
        chk("t6_persist_10", rd, 32'hDEAABEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
